instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Instruction queue between the decode stage and dispatch/issue. It is the receiving end of decode's load_queue/instruction push interface.
- Buffers decoded instr_struct entries in program order and presents the oldest entry to dispatch (show-ahead, valid/ready pop).
- Applies backpressure to fetch via full/almost_full.
- Discards all contents on a pipeline flush (branch mispredict).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full_o asserts.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- enq_i  input  1  push request from decode (decode's load_queue)
- instr_i  input  instr_struct  decoded instruction from decode
- flush_i  input  1  squash all queued entries
- deq_i  input  1  dispatch accepts head entry this cycle
- valid_o  output  1  head entry valid (queue non-empty)
- instr_o  output  instr_struct  head entry; all-zero when empty
- full_o  output  1  occupancy == DEPTH
- almost_full_o  output  1  occupancy >= AF_LEVEL
- count_o  output  $clog2(DEPTH)+1  current occupancy
- overflow_o  output  1  sticky: a push was dropped while full

Behaviour:
- Reset (rst low, async):
  - head pointer, tail pointer and count go to 0; overflow_o goes to 0.
  - valid_o=0, full_o=0, almost_full_o=0 (for AF_LEVEL>0), instr_o all-zero.
  - Storage contents need not be cleared.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is tracked separately; full/empty derive from count only.
- Push accepted: push = enq_i && !flush_i && (count<DEPTH || pop).
  - On a clock edge with push, instr_i is written to mem[tail], then tail++.
- Pop accepted: pop = deq_i && valid_o && !flush_i.
  - On a clock edge with pop, head++.
- count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged, including when full (the slot freed by the pop is reused in the same cycle).
- Read side is combinational from mem[head] (zero-latency show-ahead).
  - A pushed entry becomes visible on instr_o the cycle after the push edge. There is no same-cycle bypass.
  - With an empty queue, simultaneous enq_i and deq_i: the push is accepted and the pop is ignored.
- deq_i while empty: ignored, no pointer movement.
- enq_i while full with no pop: entry dropped, overflow_o set (sticky until reset). Decode is responsible for respecting full_o; overflow_o is a debug/assert hook.
- flush_i (synchronous):
  - At the next edge, head=tail=0 and count=0.
  - Any enq_i or deq_i in the same cycle is ignored.
  - During the flush cycle, outputs still reflect pre-flush state. From the next cycle, valid_o=0.
- instr_o fields pass through unmodified, including pc, rd and branch_id. The queue does not interpret opcodes.
- All outputs except instr_o are registered or derived from registered count only (no combinational path from enq_i/deq_i to full_o/valid_o).
- Reset asserted mid-operation overrides everything immediately; the queue is empty after release.

Decomposition:
- instr_struct and opcode enums stay in rv32i_types.
- Add IQ_DEPTH (default 8) to rv32i_types so fetch, decode and dispatch size against one constant.
- No sub-module required. Storage is an unpacked array of instr_struct inside instr_queue, with pointer/count logic in one always_ff.

Test Plan:
- Reset then idle -> valid_o=0, count_o=0, full_o=0, instr_o.instruction=32'h0.
- Push 3 entries (instruction=32'h00500093/32'h00A00113/32'h002081B3, pc=0x60/0x64/0x68), then deq_i held high -> instr_o.pc is 0x60, 0x64, 0x68 on consecutive cycles; count_o is 3,2,1,0; valid_o drops after the third pop.
- Fill 8 entries -> count_o=8, full_o=1, almost_full_o high from count 7. Push without pop -> count_o stays 8, overflow_o=1, head unchanged.
- Full queue with enq_i and deq_i in the same cycle -> count_o stays 8, head pc advances by one entry, new entry appears at tail. Repeat 20 times so pointers wrap; order is preserved.
- 5 entries queued, flush_i with enq_i=1 and deq_i=1 in the same cycle -> next cycle count_o=0, valid_o=0. A following push of pc=0x200 appears at head the cycle after.
- rst driven low asynchronously mid-burst (count_o=4) -> outputs go to reset values before the next clk edge. After release, the first push is the first pop.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types and the instruction-queue depth used by fetch,
// decode and dispatch.
package rv32i_types;

  localparam int IQ_DEPTH = 8;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } rv32i_opcode_t;

  typedef struct packed {
    logic [31:0]   instruction;
    logic [31:0]   pc;
    rv32i_opcode_t opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic [3:0]    branch_id;
  } instr_struct;

endpackage

// File: rtl/instr_queue.sv
// Program-order instruction buffer between decode and dispatch with
// show-ahead head, full/almost-full backpressure and flush-on-mispredict.
module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_i,
  input  instr_struct              instr_i,
  input  logic                     flush_i,
  input  logic                     deq_i,
  output logic                     valid_o,
  output instr_struct              instr_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  instr_struct mem [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          push;
  logic          pop;

  // Status depends only on registered count, never on enq_i/deq_i.
  assign valid_o       = (count_reg != '0);
  assign full_o        = (count_reg == DEPTH_C);
  assign almost_full_o = (count_reg >= AF_C);
  assign count_o       = count_reg;
  assign overflow_o    = overflow_reg;
  assign instr_o       = valid_o ? mem[head_reg] : '0;

  // A pop on a full queue frees the slot the same-cycle push reuses.
  assign pop  = deq_i && valid_o && !flush_i;
  assign push = enq_i && !flush_i && (!full_o || pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
      if (enq_i && !push) overflow_reg <= 1'b1;
    end
  end

  // Storage is not reset; the zero-when-empty mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= instr_i;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed plus randomized bench for instr_queue, checked against a
// queue-based reference model of the buffer contents.
module tb_instr_queue;
  import rv32i_types::*;

  localparam int DEPTH = IQ_DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        deq_i = 1'b0;
  instr_struct instr_i = '0;
  logic        valid_o;
  instr_struct instr_o;
  logic        full_o;
  logic        almost_full_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  instr_queue dut (
    .clk(clk), .rst(rst), .enq_i(enq_i), .instr_i(instr_i),
    .flush_i(flush_i), .deq_i(deq_i), .valid_o(valid_o), .instr_o(instr_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  instr_struct model_q[$];
  logic        model_ovf = 1'b0;

  function automatic instr_struct mk(input logic [31:0] ins, input logic [31:0] pc);
    instr_struct s;
    s = '0;
    s.instruction = ins;
    s.pc          = pc;
    s.opcode      = OP_IMM;
    s.rd          = ins[11:7];
    s.branch_id   = pc[5:2];
    return s;
  endfunction

  function automatic instr_struct rand_instr();
    instr_struct s;
    s.instruction = $urandom;
    s.pc          = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
    case ($urandom_range(0, 3))
      0:       s.opcode = OP_IMM;
      1:       s.opcode = OP_REG;
      2:       s.opcode = OP_LOAD;
      default: s.opcode = OP_BR;
    endcase
    s.rd        = 5'($urandom);
    s.rs1       = 5'($urandom);
    s.rs2       = 5'($urandom);
    s.imm       = $urandom;
    s.branch_id = 4'($urandom);
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    instr_struct exp_instr;
    int          n;
    n = model_q.size();
    exp_instr = (n > 0) ? model_q[0] : '0;
    checks++;
    assert (valid_o === (n > 0)) else begin
      errors++; $error("FAIL %s valid: got %0b want %0b", tag, valid_o, (n > 0));
    end
    checks++;
    assert (count_o === 4'(n)) else begin
      errors++; $error("FAIL %s count: got %0d want %0d", tag, count_o, n);
    end
    checks++;
    assert (full_o === (n == DEPTH)) else begin
      errors++; $error("FAIL %s full: got %0b want %0b", tag, full_o, (n == DEPTH));
    end
    checks++;
    assert (almost_full_o === (n >= DEPTH - 1)) else begin
      errors++; $error("FAIL %s almost_full: got %0b want %0b", tag, almost_full_o, (n >= DEPTH - 1));
    end
    checks++;
    assert (overflow_o === model_ovf) else begin
      errors++; $error("FAIL %s overflow: got %0b want %0b", tag, overflow_o, model_ovf);
    end
    checks++;
    assert (instr_o === exp_instr) else begin
      errors++; $error("FAIL %s instr: got pc=%0h ins=%0h want pc=%0h ins=%0h",
                       tag, instr_o.pc, instr_o.instruction, exp_instr.pc, exp_instr.instruction);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the model.
  task automatic step(input string tag, input logic enq, input instr_struct ins,
                      input logic deq, input logic fl);
    bit do_pop, do_push;
    enq_i = enq; instr_i = ins; deq_i = deq; flush_i = fl;
    @(negedge clk);
    check_outputs(tag);
    $display("%s enq=%0b deq=%0b flush=%0b count=%0d head_pc=%0h",
             tag, enq, deq, fl, count_o, instr_o.pc);
    @(posedge clk);
    do_pop  = deq && (model_q.size() > 0) && !fl;
    do_push = enq && !fl && (model_q.size() < DEPTH || do_pop);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(ins);
      if (enq && !do_push) model_ovf = 1'b1;
    end
    #1;
    enq_i = 1'b0; deq_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    // Reset and idle
    #12 rst = 1'b1;
    @(posedge clk); #1;
    step("idle", 1'b0, '0, 1'b0, 1'b0);
    checks++;
    assert (instr_o.instruction === 32'h0) else begin
      errors++; $error("FAIL idle_instruction: got %0h want 0", instr_o.instruction);
    end

    // Three pushes, then dequeue held high
    step("push0", 1'b1, mk(32'h00500093, 32'h60), 1'b0, 1'b0);
    step("push1", 1'b1, mk(32'h00A00113, 32'h64), 1'b0, 1'b0);
    step("push2", 1'b1, mk(32'h002081B3, 32'h68), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, mk(32'h13 + i, 32'h100 + 4 * i), 1'b0, 1'b0);
    step("overflow", 1'b1, mk(32'hDEAD, 32'hBAD0), 1'b0, 1'b0);
    step("after_ovf", 1'b0, '0, 1'b0, 1'b0);

    // Full with simultaneous push/pop; pointers wrap
    for (int i = 0; i < 20; i++) step("full_swap", 1'b1, mk(32'h1000 + i, 32'h400 + 4 * i), 1'b1, 1'b0);
    step("swap_end", 1'b0, '0, 1'b0, 1'b0);

    // Reduce to five entries, flush with enq and deq active
    for (int i = 0; i < 3; i++) step("to5", 1'b0, '0, 1'b1, 1'b0);
    step("flush", 1'b1, mk(32'hF00D, 32'h300), 1'b1, 1'b1);
    step("post_flush", 1'b1, mk(32'h00000013, 32'h200), 1'b0, 1'b0);
    step("head_200", 1'b0, '0, 1'b0, 1'b0);
    step("pop_200", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) step("burst", 1'b1, rand_instr(), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (count_o === 4'd0 && !valid_o && !full_o && !almost_full_o && !overflow_o && instr_o === '0)
      else begin
        errors++; $error("FAIL async_reset: got count=%0d valid=%0b ovf=%0b want 0/0/0",
                         count_o, valid_o, overflow_o);
      end
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step("rst_push", 1'b1, mk(32'h00100093, 32'h500), 1'b0, 1'b0);
    step("rst_push2", 1'b1, mk(32'h00200093, 32'h504), 1'b0, 1'b0);
    step("rst_pop", 1'b0, '0, 1'b1, 1'b0);
    step("rst_pop2", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), rand_instr(),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
    end
    step("final", 1'b0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
